// File: rtl/col_bram_pingpong_ctrl.sv
// Ping/pong column-BRAM sequencer: fill-bank writes, read sweep and bank swap.
// Define COL_BRAM_CTRL_TLAST_CHK_EN to enable the sticky s_tlast framing check.
module col_bram_pingpong_ctrl #(
  parameter int ADDR_WIDTH = 9,
  parameter int NUM_BRAM   = 8,
  parameter int NUM_COLS   = 512,
  parameter int RD_LAT     = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic [511:0]          s_tdata,
  input  logic                  s_tlast,
  output logic [NUM_BRAM-1:0]   bram_ena,
  output logic [NUM_BRAM-1:0]   bram_wea,
  output logic [ADDR_WIDTH-1:0] bram_addra,
  output logic [511:0]          bram_dina,
  input  logic                  rd_start,
  output logic                  rd_busy,
  output logic                  bram_enb,
  output logic [ADDR_WIDTH-1:0] bram_addrb,
  output logic                  rd_valid,
  output logic                  rd_last,
  output logic                  rd_done,
  output logic                  ping_pong_sel,
  output logic                  ping_pong_sel_d3,
  output logic                  tlast_err
);

  typedef enum logic {F_FILL, F_FULL} fill_state_t;
  typedef enum logic [1:0] {R_IDLE, R_RUN, R_DRAIN} rd_state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_COL = ADDR_WIDTH'(NUM_COLS - 1);

  fill_state_t           r_fstate, w_fstate_nxt;
  rd_state_t             r_rstate, w_rstate_nxt;
  logic [ADDR_WIDTH-1:0] r_fill_cnt;
  logic [ADDR_WIDTH-1:0] r_rd_cnt;
  logic                  r_fill_last;
  logic                  r_rd_loaded;
  logic                  r_sel;
  logic [RD_LAT-1:0]     r_sel_sr;
  logic [RD_LAT-1:0]     r_vld_sr;
  logic [RD_LAT-1:0]     r_last_sr;
  logic                  r_rd_done;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_addra;
  logic [511:0]          r_dina;
  logic                  r_tlast_err;
  logic                  w_accept;
  logic                  w_swap;
  logic                  w_start;
  logic                  w_drain_end;
  logic                  w_col_last;

  assign w_accept    = s_tvalid && s_tready;
  assign w_swap      = (r_fstate == F_FULL) && (r_rstate == R_IDLE) && !r_rd_loaded;
  assign w_start     = rd_start && (r_rstate == R_IDLE) && r_rd_loaded;
  // The last column leaving the read pipe marks the end of the drain window.
  assign w_drain_end = (r_rstate == R_DRAIN) && r_last_sr[RD_LAT-1];
  assign w_col_last  = bram_enb && (r_rd_cnt == LAST_COL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fstate <= F_FILL;
      r_rstate <= R_IDLE;
    end else begin
      r_fstate <= w_fstate_nxt;
      r_rstate <= w_rstate_nxt;
    end
  end

  // Full is entered one edge after the last beat so its write lands on the old bank.
  always_comb begin
    w_fstate_nxt = r_fstate;
    s_tready     = 1'b0;
    case (r_fstate)
      F_FILL: begin
        s_tready = !r_fill_last;
        if (r_fill_last) w_fstate_nxt = F_FULL;
      end
      F_FULL: begin
        if (w_swap) w_fstate_nxt = F_FILL;
      end
      default: w_fstate_nxt = F_FILL;
    endcase
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    bram_enb     = 1'b0;
    rd_busy      = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        if (w_start) w_rstate_nxt = R_RUN;
      end
      R_RUN: begin
        bram_enb = 1'b1;
        rd_busy  = 1'b1;
        if (r_rd_cnt == LAST_COL) w_rstate_nxt = R_DRAIN;
      end
      R_DRAIN: begin
        rd_busy = 1'b1;
        if (w_drain_end) w_rstate_nxt = R_IDLE;
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fill_cnt  <= '0;
      r_fill_last <= 1'b0;
      r_wr_en     <= 1'b0;
      r_addra     <= '0;
      r_dina      <= '0;
    end else begin
      r_wr_en <= w_accept;
      if (w_accept) begin
        r_addra <= r_fill_cnt;
        r_dina  <= s_tdata;
      end
      if (w_swap) begin
        r_fill_cnt  <= '0;
        r_fill_last <= 1'b0;
      end else if (w_accept) begin
        if (r_fill_cnt == LAST_COL) r_fill_last <= 1'b1;
        else                        r_fill_cnt  <= r_fill_cnt + ADDR_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_cnt    <= '0;
      r_rd_loaded <= 1'b0;
      r_rd_done   <= 1'b0;
      r_vld_sr    <= '0;
      r_last_sr   <= '0;
      r_sel       <= 1'b0;
      r_sel_sr    <= '0;
    end else begin
      if (w_start) r_rd_cnt <= '0;
      else if (bram_enb && (r_rd_cnt != LAST_COL)) r_rd_cnt <= r_rd_cnt + ADDR_WIDTH'(1);
      if (w_swap)           r_rd_loaded <= 1'b1;
      else if (w_drain_end) r_rd_loaded <= 1'b0;
      if (w_swap) r_sel <= ~r_sel;
      r_rd_done <= w_drain_end;
      r_vld_sr  <= (r_vld_sr << 1) | RD_LAT'(bram_enb);
      r_last_sr <= (r_last_sr << 1) | RD_LAT'(w_col_last);
      r_sel_sr  <= (r_sel_sr << 1) | RD_LAT'(r_sel);
    end
  end

`ifdef COL_BRAM_CTRL_TLAST_CHK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_tlast_err <= 1'b0;
    else if (w_accept && (s_tlast != (r_fill_cnt == LAST_COL))) r_tlast_err <= 1'b1;
  end
`else
  logic w_unused_tlast;
  assign w_unused_tlast = s_tlast;
  assign r_tlast_err    = 1'b0;
`endif

  assign bram_ena         = {NUM_BRAM{r_wr_en}};
  assign bram_wea         = {NUM_BRAM{r_wr_en}};
  assign bram_addra       = r_addra;
  assign bram_dina        = r_dina;
  assign bram_addrb       = r_rd_cnt;
  assign rd_valid         = r_vld_sr[RD_LAT-1];
  assign rd_last          = r_last_sr[RD_LAT-1];
  assign rd_done          = r_rd_done;
  assign ping_pong_sel    = r_sel;
  assign ping_pong_sel_d3 = r_sel_sr[RD_LAT-1];
  assign tlast_err        = r_tlast_err;

endmodule

// File: tb/tb_col_bram_pingpong_ctrl.sv
// Bench for col_bram_pingpong_ctrl: random beats/rd_start against a timestamp-based
// reference of fills, sweeps and bank swaps.
module tb_col_bram_pingpong_ctrl;
  localparam int AW = 9;
  localparam int NB = 8;
  localparam int N  = 512;
  localparam int RL = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [511:0]  s_tdata = '0;
  logic          s_tlast = 1'b0;
  logic [NB-1:0] bram_ena, bram_wea;
  logic [AW-1:0] bram_addra, bram_addrb;
  logic [511:0]  bram_dina;
  logic          rd_start = 1'b0;
  logic          rd_busy, bram_enb, rd_valid, rd_last, rd_done;
  logic          ping_pong_sel, ping_pong_sel_d3, tlast_err;

  always #5 clk = ~clk;

  col_bram_pingpong_ctrl #(.ADDR_WIDTH(AW), .NUM_BRAM(NB), .NUM_COLS(N), .RD_LAT(RL)) dut (
    .clk(clk), .rst(rst),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
    .bram_ena(bram_ena), .bram_wea(bram_wea), .bram_addra(bram_addra), .bram_dina(bram_dina),
    .rd_start(rd_start), .rd_busy(rd_busy), .bram_enb(bram_enb), .bram_addrb(bram_addrb),
    .rd_valid(rd_valid), .rd_last(rd_last), .rd_done(rd_done),
    .ping_pong_sel(ping_pong_sel), .ping_pong_sel_d3(ping_pong_sel_d3), .tlast_err(tlast_err)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference: beats accepted in the current fill, edge of the last beat,
  // start edge of the current sweep, and per-window select history.
  int           m_filled, m_full_edge, m_t, m_waddr;
  bit           m_full, m_loaded, m_sel, m_terr, m_wr;
  logic [511:0] m_wdata;
  bit           m_hist [0:3];

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic bit in_busy(int w);
    return (w >= m_t) && (w <= m_t + N + RL - 1);
  endfunction

  task automatic model_reset();
    m_filled = 0; m_full_edge = 0; m_t = -100000; m_waddr = 0;
    m_full = 0; m_loaded = 0; m_sel = 0; m_terr = 0; m_wr = 0; m_wdata = '0;
    for (int i = 0; i < 4; i++) m_hist[i] = 0;
  endtask

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
      $error("%s differs from reference", tag);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".s_tready"}, s_tready, 1'b1);
    chk({tag, ".bram_ena"}, bram_ena, '0);
    chk({tag, ".bram_wea"}, bram_wea, '0);
    chk({tag, ".bram_addra"}, bram_addra, '0);
    chk({tag, ".bram_dina"}, bram_dina, '0);
    chk({tag, ".bram_enb"}, bram_enb, 1'b0);
    chk({tag, ".bram_addrb"}, bram_addrb, '0);
    chk({tag, ".rd_valid"}, rd_valid, 1'b0);
    chk({tag, ".rd_last"}, rd_last, 1'b0);
    chk({tag, ".rd_done"}, rd_done, 1'b0);
    chk({tag, ".rd_busy"}, rd_busy, 1'b0);
    chk({tag, ".sel"}, ping_pong_sel, 1'b0);
    chk({tag, ".sel_d3"}, ping_pong_sel_d3, 1'b0);
    chk({tag, ".tlast_err"}, tlast_err, 1'b0);
  endtask

  // One clock: drive inputs, advance the reference by one edge, compare 1ns later.
  task automatic step(input bit tv, input logic [511:0] td, input bit tl, input bit rs);
    bit busy_prev, acc, swap, start, en;
    s_tvalid = tv; s_tdata = td; s_tlast = tl; rd_start = rs;
    @(posedge clk);
    cyc++;
    busy_prev = in_busy(cyc - 1);
    acc   = tv && (m_filled < N);
    swap  = m_full && (cyc >= m_full_edge + 2) && !m_loaded && !busy_prev;
    start = rs && m_loaded && !busy_prev;
    m_wr  = acc;
    if (acc) begin
      m_waddr = m_filled;
      m_wdata = td;
`ifdef COL_BRAM_CTRL_TLAST_CHK_EN
      if (tl != (m_filled == N - 1)) m_terr = 1;
`endif
      m_filled++;
      if (m_filled == N) begin m_full = 1; m_full_edge = cyc; end
    end
    if (m_t + N + RL == cyc) m_loaded = 0;
    if (swap) begin m_sel = !m_sel; m_loaded = 1; m_filled = 0; m_full = 0; end
    if (start) m_t = cyc;
    for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = m_sel;
    #1;
    en = (cyc >= m_t) && (cyc <= m_t + N - 1);
    chk("s_tready", s_tready, m_filled < N);
    chk("bram_wea", bram_wea, {NB{m_wr}});
    chk("bram_ena", bram_ena, {NB{m_wr}});
    if (m_wr) begin
      chk("bram_addra", bram_addra, m_waddr);
      chk("bram_dina", bram_dina, m_wdata);
    end
    chk("bram_enb", bram_enb, en);
    if (en) chk("bram_addrb", bram_addrb, cyc - m_t);
    chk("rd_valid", rd_valid, (cyc >= m_t + RL) && (cyc <= m_t + N - 1 + RL));
    chk("rd_last", rd_last, cyc == m_t + N - 1 + RL);
    chk("rd_done", rd_done, cyc == m_t + N + RL);
    chk("rd_busy", rd_busy, in_busy(cyc));
    chk("sel", ping_pong_sel, m_sel);
    chk("sel_d3", ping_pong_sel_d3, m_hist[RL]);
    chk("tlast_err", tlast_err, m_terr);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 chk_reset("reset");
    @(negedge clk) rst = 1'b0;

    // rd_start with nothing loaded must be ignored.
    for (int i = 0; i < 4; i++) step(1'b0, rand512(), 1'b0, 1'b1);

    // First fill with random gaps; swaps immediately since nothing is loaded.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, rand512(), m_filled == N - 1, $urandom_range(0, 7) == 0);
      if (m_sel) break;
    end
    for (int i = 0; i < 4; i++) step(1'b0, rand512(), 1'b0, 1'b0);

    // Sweep of the loaded bank while the second fill streams back-to-back,
    // with a bad tlast on beat 100 and rd_start pulsed in the swap cycle.
    step(1'b1, rand512(), m_filled == 100 || m_filled == N - 1, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      step((m_filled < N) ? 1'b1 : 1'($urandom_range(0, 1)), rand512(),
           m_filled == 100 || m_filled == N - 1,
           (cyc == m_t + N + RL) ? 1'b1 : 1'($urandom_range(0, 15) == 0));
      if (!m_sel) break;
    end

    // Second sweep, interrupted by an asynchronous reset at column 200.
    step(1'b0, rand512(), 1'b0, 1'b1);
    for (int i = 0; i < 400 && cyc != m_t + 200; i++)
      step($urandom_range(0, 1) != 0, rand512(), m_filled == N - 1, $urandom_range(0, 7) == 0);
    chk("col200.addrb", bram_addrb, 200);
    #2 rst = 1'b1;
    #1 chk_reset("midrst");
    model_reset();
    @(posedge clk);
    #1 chk_reset("midrst_held");
    #3 rst = 1'b0;
    for (int i = 0; i < 8; i++) step(1'b0, rand512(), 1'b0, 1'b1);
    for (int i = 0; i < 24; i++)
      step($urandom_range(0, 1) != 0, rand512(), 1'b0, $urandom_range(0, 3) == 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/col_bram_pingpong_ctrl.md
# col_bram_pingpong_ctrl

Sequencer for the ping/pong column-BRAM store that holds matrix B (transposed, one 512-bit column per address) in the DSP58 GeMM datapath. Accepts the B-matrix column stream from the DDR mover and drives the fill-bank write port. Issues the column read sweep to the DUT-side read port. Owns `ping_pong_sel` and its 3-cycle-delayed copy, swapping banks only when the fill bank is complete and the read bank has been fully consumed and drained.

## Interface
Parameters:
- `ADDR_WIDTH`, 9: BRAM address width.
- `NUM_BRAM`, 8: number of 64-bit BRAM slices per bank.
- `NUM_COLS`, 512: columns per matrix; beats per fill and addresses per read sweep (≤ 2^ADDR_WIDTH).
- `RD_LAT`, 3: port-B read latency in cycles.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `s_tvalid` in 1: column beat valid.
- `s_tready` out 1: column beat accepted when high with `s_tvalid`.
- `s_tdata` in 512: one column.
- `s_tlast` in 1: last column of matrix.
- `bram_ena` out NUM_BRAM: port-A enable (all bits equal).
- `bram_wea` out NUM_BRAM: port-A write enable (all bits equal).
- `bram_addra` out ADDR_WIDTH: write address.
- `bram_dina` out 512: write data.
- `rd_start` in 1: request one read sweep of the loaded bank.
- `rd_busy` out 1: sweep or drain in progress.
- `bram_enb` out 1: port-B enable.
- `bram_addrb` out ADDR_WIDTH: read address.
- `rd_valid` out 1: `bram_doutb` valid this cycle.
- `rd_last` out 1: with `rd_valid`, marks column NUM_COLS-1.
- `rd_done` out 1: one-cycle pulse at sweep completion.
- `ping_pong_sel` out 1: 0 = fill ping/read pong; 1 = fill pong/read ping.
- `ping_pong_sel_d3` out 1: `ping_pong_sel` delayed RD_LAT cycles.
- `tlast_err` out 1: sticky framing error.

## Operation
- Fill FSM: `F_FILL` (s_tready=1) → `F_FULL` (s_tready=0) → back to `F_FILL` on swap.
  - Each accepted beat registers `bram_ena`/`bram_wea` to all ones, `bram_addra` to the fill counter, and `bram_dina` to `s_tdata`.
  - The fill counter increments per beat. On beat NUM_COLS-1, the FSM enters `F_FULL`.
- Read FSM: `R_IDLE` → `R_RUN` → `R_DRAIN` → `R_IDLE`.
  - `rd_start` is honoured only in `R_IDLE` with `rd_loaded`=1; otherwise it is ignored (no queueing).
  - `R_RUN` asserts `bram_enb` with addresses 0..NUM_COLS-1, one per cycle.
  - `R_DRAIN` lasts RD_LAT cycles. On exit, `rd_done` pulses and `rd_loaded` clears.
- Swap condition, evaluated combinationally: `F_FULL` && `R_IDLE` && !`rd_loaded`. At the next edge:
  - `ping_pong_sel` toggles.
  - `rd_loaded` sets.
  - The fill counter clears and the fill FSM returns to `F_FILL`.
- After reset, the first completed fill swaps immediately, because nothing is loaded.
- Simultaneous events: when the read completes (`rd_done`) in the same cycle that the fill becomes full, the swap occurs on the following edge. `rd_start` in the swap cycle is ignored, because `rd_loaded`=0 in that cycle.
- `rd_busy` = (`R_RUN` or `R_DRAIN`).

## Timing
- Reset values: all outputs 0, except `s_tready`=1. Reset also sets both FSMs idle (`F_FILL`, `R_IDLE`), both counters 0, `rd_loaded`=0 and `tlast_err`=0.
- Reset mid-operation drops any in-progress sweep or fill with no completion pulse.
- Write latency: a beat accepted at edge t drives the write strobes during cycle t+1. `F_FULL` is entered at edge t+1, so the earliest swap is edge t+2. The last write therefore always sees the old `ping_pong_sel`.
- Read sweep: `rd_start` sampled at edge t gives `bram_enb`/address k during cycle t+1+k. The matching `rd_valid` occurs at cycle t+1+k+RD_LAT.
  - `rd_last` occurs at cycle t+NUM_COLS+RD_LAT.
  - `rd_done` occurs at cycle t+NUM_COLS+RD_LAT+1.
- `ping_pong_sel_d3` is a 3-stage shift of `ping_pong_sel` (RD_LAT stages). Because swaps only happen after a drain, the read data mux is always stable during `rd_valid`.
- Counter widths are ADDR_WIDTH. There is no wrap-around: counters stop at NUM_COLS-1 and clear only on swap or sweep start.

## Configuration
- `COL_BRAM_CTRL_TLAST_CHK_EN` defined:
  - `tlast_err` sets (sticky until reset) if `s_tlast`=1 on a beat other than NUM_COLS-1, or `s_tlast`=0 on beat NUM_COLS-1.
  - Counting is unaffected by the error.
- Not defined: `s_tlast` is ignored and `tlast_err` is tied to 0.

## Test plan
- Reset, then 512 beats with `s_tvalid` held high → 512 writes at addresses 0..511. `s_tready`=0 after beat 511. `ping_pong_sel` goes 0→1 two edges after the last beat is accepted. `F_FILL` is re-entered.
- After the first swap, pulse `rd_start` → `bram_enb` for 512 cycles at addresses 0..511. `rd_valid` starts 4 cycles after the `rd_start` edge. `rd_last` coincides with column 511. `rd_done` follows 1 cycle later.
- Second fill completes mid-sweep → `s_tready` stays 0 and `ping_pong_sel` holds until one edge after `rd_done`, then toggles 1→0.
- `rd_start` pulsed with `rd_loaded`=0 (before the first fill completes) → no `bram_enb` and `rd_busy` stays 0.
- With the macro defined, `s_tlast` on beat 100 → `tlast_err`=1 and stays 1. The fill still completes at beat 511.
- Assert `rst` during sweep column 200 → all outputs immediately return to their reset values (`s_tready`=1, all others 0). No `rd_done` is generated.
